rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 8: ROM address width.
REQ-003 SHALL have parameter DATA_W, default 16: ROM data width.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port i_req, input, NUM_CH: per-channel read request, level.
REQ-007 SHALL have port i_addr, input, NUM_CH*ADDR_W: per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port o_grant, output, NUM_CH: one-hot, one-cycle grant pulse.
REQ-009 SHALL have port o_data_valid, output, NUM_CH: one-hot, one-cycle return strobe.
REQ-010 SHALL have port o_data, output, DATA_W: shared read data bus, qualified by o_data_valid.
REQ-011 SHALL have port o_rom_addr, output, ADDR_W: address to the synchronous ROM.
REQ-012 SHALL have port i_rom_data, input, DATA_W: ROM data, valid one cycle after o_rom_addr.

Function
REQ-013 SHALL compute eligible = i_req & ~o_grant each cycle; a channel granted in the current cycle is masked.
REQ-014 SHALL pick at most one eligible channel per cycle, round-robin: search starts at last_granted+1, wraps modulo NUM_CH.
REQ-015 SHALL, for winner k chosen in cycle T, drive o_grant = 1<<k and o_rom_addr = i_addr[k] (sampled in T) in cycle T+1, both registered.
REQ-016 SHALL update last_granted to k at the same edge; unchanged when no channel is eligible.
REQ-017 SHALL drive o_grant = 0 in any cycle following a cycle with no eligible channel; o_rom_addr holds its previous value.
REQ-018 SHALL drive o_data_valid = 1<<k in cycle T+2 (one cycle after o_grant) via a one-stage delay of o_grant.
REQ-019 SHALL drive o_data = i_rom_data combinationally; value meaningful only when o_data_valid != 0.
REQ-020 SHALL sustain one grant per cycle when >=2 channels request; a single channel holding i_req high is granted every other cycle.
REQ-021 SHALL treat i_req held high in the cycle after its grant as a new request only from the cycle after that (masking per REQ-013).
REQ-022 SHALL ignore i_addr of non-winning channels; requesters hold i_addr stable while i_req is high and not yet granted.
REQ-023 SHALL guarantee any continuously requesting channel a grant within NUM_CH cycles (no starvation).
REQ-024 SHALL never assert more than one bit of o_grant or o_data_valid in a cycle.

Reset
REQ-025 SHALL, while i_rst is high at a clock edge, set o_grant = 0, o_data_valid = 0, o_rom_addr = 0, last_granted = NUM_CH-1 (channel 0 highest priority first).
REQ-026 SHALL drop in-flight grants on reset: a grant issued in the cycle before i_rst produces no o_data_valid.
REQ-027 SHALL resume arbitration in the first cycle after i_rst deasserts, with first grant visible one cycle later.

Verification
REQ-028 Single request: after reset, i_req=0001, addr0=0x10, ROM[0x10]=0xBEEF -> o_grant=0001 at T+1, o_rom_addr=0x10, o_data_valid=0001 with o_data=0xBEEF at T+2.
REQ-029 All request: i_req=1111 held, addr k=0x20+k -> grant order ch0,1,2,3,0,... one per cycle, each o_data_valid one cycle after grant with data ROM[0x20+k].
REQ-030 Lone hold: i_req=0100 held 8 cycles -> o_grant=0100 every other cycle (4 grants), no back-to-back grants.
REQ-031 Fairness/wrap: ch3 granted last, then i_req=1001 -> next grant ch0, then ch3, alternating.
REQ-032 Reset mid-flight: i_req=0010, assert i_rst the cycle o_grant=0010 is high -> o_data_valid stays 0000, outputs zero; after release grant ch1 again at first-eligible cycle +1.
REQ-033 Checker on every cycle: o_grant and o_data_valid one-hot-or-zero, o_data_valid equals o_grant delayed one cycle.

Source files
------------

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Round-robin arbiter that shares one synchronous ROM among
//            NUM_CH requesting channels. A winner picked in cycle T sees its
//            grant pulse and ROM address in T+1. The ROM answers one cycle
//            later, so the data-valid strobe follows in T+2.
// Ports    : i_clk, i_rst         clock, synchronous active-high reset
//            i_req[NUM_CH]        per-channel level request
//            i_addr[NUM_CH*ADDR_W] per-channel address, channel k at k*ADDR_W
//            o_grant[NUM_CH]      one-hot grant pulse (registered)
//            o_data_valid[NUM_CH] one-hot return strobe, o_grant delayed 1
//            o_data[DATA_W]       shared read data (i_rom_data pass-through)
//            o_rom_addr[ADDR_W]   address to the ROM (registered)
//            i_rom_data[DATA_W]   ROM read data, one cycle after o_rom_addr
// Revision : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  output logic [NUM_CH-1:0]        o_grant,
  output logic [NUM_CH-1:0]        o_data_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [ADDR_W-1:0]        o_rom_addr,
  input  logic [DATA_W-1:0]        i_rom_data
);

  localparam int                c_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] c_ONE   = NUM_CH'(1);

  logic [NUM_CH-1:0]  r_grant;
  logic [NUM_CH-1:0]  r_data_valid;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [c_IDX_W-1:0] r_last;

  logic [NUM_CH-1:0]  w_elig;
  logic               w_found;
  logic [c_IDX_W-1:0] w_win;
  logic [c_IDX_W-1:0] w_idx;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_CH];

  // Unpack the flat address bus so the winner can be selected by index.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_addr_unpack
    assign w_addr_arr[k] = i_addr[k*ADDR_W +: ADDR_W];
  end

  // A channel granted this cycle is masked so that a held request is
  // treated as new only one cycle later.
  assign w_elig = i_req & ~r_grant;

  // Search from last+1 upwards, wrapping. Offset NUM_CH lands back on the
  // last winner, so it is considered only when no other channel is eligible.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      w_idx = c_IDX_W'((int'(r_last) + off) % NUM_CH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant      <= '0;
      r_data_valid <= '0;
      r_rom_addr   <= '0;
      r_last       <= c_IDX_W'(NUM_CH - 1);
    end else begin
      // The ROM returns data one cycle after the address, so the strobe is
      // simply the grant delayed by one stage. Reset clears it, which drops
      // any grant that was in flight.
      r_data_valid <= r_grant;
      if (w_found) begin
        r_grant    <= c_ONE << w_win;
        r_rom_addr <= w_addr_arr[w_win];
        r_last     <= w_win;
      end else begin
        r_grant    <= '0;
      end
    end
  end

  assign o_grant      = r_grant;
  assign o_data_valid = r_data_valid;
  assign o_rom_addr   = r_rom_addr;
  assign o_data       = i_rom_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_arbiter
// Purpose  : Self-checking bench for rom_arbiter with a behavioural ROM and a
//            round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    grant;
  logic [N-1:0]    dvalid;
  logic [DW-1:0]   data;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q;
  logic [DW-1:0]   rom [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  always @(posedge clk) rom_q <= rom[rom_addr];

  rom_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_addr      (addr),
    .o_grant     (grant),
    .o_data_valid(dvalid),
    .o_data      (data),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_q)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state and the expectations for the cycle after a tick.
  int            m_last;
  logic [N-1:0]  m_grant;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  e_grant;
  logic [N-1:0]  e_valid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  // Per-cycle structural checker: one-hot-or-zero outputs and valid being
  // the previous grant (cleared when reset was sampled).
  bit           chk_en = 1'b0;
  logic         chk_rst;
  logic [N-1:0] chk_pg;
  always @(posedge clk) begin
    chk_rst <= rst;
    chk_pg  <= grant;
  end
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (!$onehot0(grant)) begin
        failures++;
        $display("FAIL onehot_grant got=%b required=one-hot-or-zero", grant);
      end
      checks++;
      if (!$onehot0(dvalid)) begin
        failures++;
        $display("FAIL onehot_valid got=%b required=one-hot-or-zero", dvalid);
      end
      checks++;
      if (dvalid !== (chk_rst ? '0 : chk_pg)) begin
        failures++;
        $display("FAIL valid_delay got=%b required=%b", dvalid, chk_rst ? '0 : chk_pg);
      end
    end
  end

  // Drive one cycle of inputs, advance the model from the arbitration rules,
  // and wait until just after the clock edge.
  task automatic tick(input logic r, input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
    int           win;
    logic [N-1:0] elig;
    rst  = r;
    req  = rq;
    addr = ad;
    if (r) begin
      e_grant = '0;
      e_valid = '0;
      e_addr  = '0;
      e_data  = '0;
      m_last  = N - 1;
    end else begin
      e_valid = m_grant;
      e_data  = rom[m_addr];
      elig    = rq & ~m_grant;
      win     = -1;
      for (int k = 1; k <= N; k++) begin
        int ch;
        ch = (m_last + k) % N;
        if (win < 0 && elig[ch]) win = ch;
      end
      if (win >= 0) begin
        e_grant = N'(1) << win;
        e_addr  = ad[win*AW +: AW];
        m_last  = win;
      end else begin
        e_grant = '0;
        e_addr  = m_addr;
      end
    end
    m_grant = e_grant;
    m_addr  = e_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, '0, '0);
    tick(1'b1, '0, '0);
    chk_en = 1'b1;
    checks++;
    if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b required=0", grant); end
    checks++;
    if (dvalid !== '0) begin failures++; $display("FAIL reset_valid got=%b required=0", dvalid); end
    checks++;
    if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h required=0", rom_addr); end
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    a = '0;
    a[0 +: AW] = 8'h10;
    tick(1'b1, '0, a);
    tick(1'b0, 4'b0001, a);
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b required=0001", grant); end
    checks++;
    if (rom_addr !== 8'h10) begin failures++; $display("FAIL single_addr got=%h required=10", rom_addr); end
    checks++;
    if (dvalid !== 4'b0000) begin failures++; $display("FAIL single_early_valid got=%b required=0000", dvalid); end
    tick(1'b0, 4'b0000, a);
    checks++;
    if (dvalid !== 4'b0001) begin failures++; $display("FAIL single_valid got=%b required=0001", dvalid); end
    checks++;
    if (data !== 16'hBEEF) begin failures++; $display("FAIL single_data got=%h required=beef", data); end
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_regrant got=%b required=0000", grant); end
  endtask

  task automatic test_all_request();
    logic [N*AW-1:0] a;
    for (int k = 0; k < N; k++) a[k*AW +: AW] = AW'(8'h20 + k);
    tick(1'b1, '0, a);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'b1111, a);
      checks++;
      if (grant !== 4'(1 << (i % N))) begin
        failures++;
        $display("FAIL all_grant[%0d] got=%b required=%b", i, grant, 4'(1 << (i % N)));
      end
      checks++;
      if (rom_addr !== AW'(8'h20 + (i % N))) begin
        failures++;
        $display("FAIL all_addr[%0d] got=%h required=%h", i, rom_addr, AW'(8'h20 + (i % N)));
      end
      if (i > 0) begin
        checks++;
        if (dvalid !== 4'(1 << ((i - 1) % N)) || data !== rom[8'h20 + ((i - 1) % N)]) begin
          failures++;
          $display("FAIL all_return[%0d] got=%b/%h required=%b/%h", i, dvalid, data,
                   4'(1 << ((i - 1) % N)), rom[8'h20 + ((i - 1) % N)]);
        end
      end
    end
    tick(1'b0, '0, a);
    tick(1'b0, '0, a);
  endtask

  task automatic test_lone_hold();
    int           ngrant;
    logic [N-1:0] prevg;
    ngrant = 0;
    prevg  = '0;
    tick(1'b1, '0, '0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 4'b0100, {$urandom, $urandom});
      checks++;
      if (grant !== e_grant) begin failures++; $display("FAIL hold_grant[%0d] got=%b required=%b", i, grant, e_grant); end
      checks++;
      if (grant !== '0 && prevg !== '0) begin
        failures++;
        $display("FAIL hold_back_to_back[%0d] got=%b after=%b required=gap", i, grant, prevg);
      end
      if (grant === 4'b0100) ngrant++;
      prevg = grant;
    end
    checks++;
    if (ngrant != 4) begin failures++; $display("FAIL hold_count got=%0d required=4", ngrant); end
    tick(1'b0, '0, '0);
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_g;
    tick(1'b1, '0, '0);
    tick(1'b0, 4'b1000, '0);
    checks++;
    if (grant !== 4'b1000) begin failures++; $display("FAIL wrap_first got=%b required=1000", grant); end
    tick(1'b0, 4'b0000, '0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 4'b1001, {$urandom, $urandom});
      exp_g = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      checks++;
      if (grant !== exp_g) begin failures++; $display("FAIL wrap_grant[%0d] got=%b required=%b", i, grant, exp_g); end
    end
    tick(1'b0, '0, '0);
  endtask

  task automatic test_reset_midflight();
    logic [N*AW-1:0] a;
    a = '0;
    a[1*AW +: AW] = 8'h5A;
    tick(1'b1, '0, a);
    tick(1'b0, 4'b0010, a);
    checks++;
    if (grant !== 4'b0010) begin failures++; $display("FAIL mid_grant got=%b required=0010", grant); end
    tick(1'b1, 4'b0010, a);
    checks++;
    if (grant !== '0 || dvalid !== '0 || rom_addr !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%b/%h required=0/0/0", grant, dvalid, rom_addr);
    end
    tick(1'b0, 4'b0010, a);
    checks++;
    if (grant !== 4'b0010 || dvalid !== '0) begin
      failures++;
      $display("FAIL mid_resume got=%b/%b required=0010/0000", grant, dvalid);
    end
    checks++;
    if (rom_addr !== 8'h5A) begin failures++; $display("FAIL mid_addr got=%h required=5a", rom_addr); end
    tick(1'b0, '0, a);
    checks++;
    if (dvalid !== 4'b0010) begin failures++; $display("FAIL mid_valid got=%b required=0010", dvalid); end
  endtask

  task automatic test_random();
    int           waitc [N];
    logic [N-1:0] rq;
    logic         r;
    rq = '0;
    foreach (waitc[k]) waitc[k] = 0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      tick(r, rq, {$urandom, $urandom});
      checks++;
      if (grant !== e_grant) begin failures++; $display("FAIL rand_grant[%0d] got=%b required=%b", i, grant, e_grant); end
      checks++;
      if (dvalid !== e_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b required=%b", i, dvalid, e_valid); end
      checks++;
      if (rom_addr !== e_addr) begin failures++; $display("FAIL rand_addr[%0d] got=%h required=%h", i, rom_addr, e_addr); end
      if (e_valid !== '0) begin
        checks++;
        if (data !== e_data) begin failures++; $display("FAIL rand_data[%0d] got=%h required=%h", i, data, e_data); end
      end
      for (int k = 0; k < N; k++) begin
        if (r || !rq[k] || grant[k]) waitc[k] = 0;
        else waitc[k]++;
        checks++;
        if (waitc[k] > N) begin
          failures++;
          $display("FAIL rand_starve ch%0d got=%0d cycles required<=%0d", k, waitc[k], N);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
    rom[8'h10] = 16'hBEEF;
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    m_last  = N - 1;
    m_grant = '0;
    m_addr  = '0;
    test_reset();
    test_single();
    test_all_request();
    test_lone_hold();
    test_wrap();
    test_reset_midflight();
    test_random();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
